// File: rtl/register_file_p_pkg.sv
// Shared definitions for the parametrised register file: op encoding,
// register index constants and a stack-pointer width helper.
package rf_pkg;

  typedef enum logic [3:0] {
    NOP    = 4'd0,
    MOV    = 4'd1,
    INCR   = 4'd2,
    DECR   = 4'd3,
    LDV_LO = 4'd4,
    LDV_HI = 4'd5,
    SETB   = 4'd6,
    FLIPB  = 4'd7,
    CALL   = 4'd8,
    RET    = 4'd9,
    CLRF   = 4'd10
  } rf_op_t;

  localparam int unsigned REG_ZERO     = 32'd0;
  localparam int unsigned VREG_DEFAULT = 32'd13;
  localparam int unsigned IMM_W        = 32'd4;

  // Pointer must count 0..depth inclusive, hence depth+1 states.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth + 32'd1);
  endfunction

endpackage

// File: rtl/register_file_p_ret_stack.sv
// Hardware return-address stack: push/pop/clear with full/empty decode and
// sticky overflow/underflow flags.
module ret_stack
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned STACK_D = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              clr,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              unf
);

  localparam int unsigned PTR_W = ptr_width(STACK_D);

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0] mem_q [STACK_D];
  logic [ADDR_W-1:0] mem_d [STACK_D];
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  assign full  = (ptr_q == PTR_W'(STACK_D));
  assign empty = (ptr_q == {PTR_W{1'b0}});
  assign ovf   = ovf_q;
  assign unf   = unf_q;

  // Top-of-stack select; reads zero when empty.
  always_comb begin
    top = {ADDR_W{1'b0}};
    for (int i = 0; i < int'(STACK_D); i++) begin
      top = (ptr_q == PTR_W'(i + 1)) ? mem_q[i] : top;
    end
  end

  // Next-state: clear first so a same-cycle setting event overrides it.
  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    ovf_d = clr ? 1'b0 : ovf_q;
    unf_d = clr ? 1'b0 : unf_q;
    if (push) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        for (int i = 0; i < int'(STACK_D); i++) begin
          mem_d[i] = (ptr_q == PTR_W'(i)) ? push_data : mem_q[i];
        end
        ptr_d = ptr_q + PTR_W'(1);
      end
    end else if (pop) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        ptr_d = ptr_q - PTR_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Stack state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= {PTR_W{1'b0}};
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < int'(STACK_D); i++) begin
        mem_q[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/register_file_p.sv
// Parametrised CPU register file with register-local ops, load/execute
// write arbitration and a nested return-address stack.
module register_file_p
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NREGS   = 16,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned STACK_D = 4,
  parameter int unsigned VREG    = VREG_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               op,
  input  logic [$clog2(NREGS)-1:0] src_sel,
  input  logic [$clog2(NREGS)-1:0] dst_sel,
  input  logic [3:0]               imm,
  input  logic                     load_en,
  input  logic [DATA_W-1:0]        load_data,
  input  logic                     stor_en,
  input  logic [ADDR_W-1:0]        npc,
  output logic [DATA_W-1:0]        src_data,
  output logic [DATA_W-1:0]        dst_data,
  output logic [DATA_W-1:0]        stor_data,
  output logic                     src_zero,
  output logic [ADDR_W-1:0]        ret_addr,
  output logic                     stack_full,
  output logic                     stack_empty,
  output logic                     ovf,
  output logic                     unf
);

  localparam int unsigned IDX_W = $clog2(NREGS);
  localparam logic [IDX_W-1:0]  VREG_IDX = IDX_W'(VREG);
  localparam logic [DATA_W-1:0] ZERO_W   = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ONE_W    = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] LO_NIB   = DATA_W'(4'hF);
  localparam logic [DATA_W-1:0] HI_NIB   = DATA_W'(8'hF0);
  localparam logic              HAS_HI   = (DATA_W >= 32'd8);

  rf_op_t            op_s;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] vreg_data;
  logic [DATA_W-1:0] bit_mask;
  logic              bit_ok;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_val;

  assign op_s      = rf_op_t'(op);
  assign src_data  = regs_q[src_sel];
  assign dst_data  = regs_q[dst_sel];
  assign vreg_data = regs_q[VREG_IDX];
  assign stor_data = stor_en ? src_data : ZERO_W;
  assign src_zero  = (src_data == ZERO_W);
  assign bit_ok    = (32'(imm) < 32'(DATA_W));
  assign bit_mask  = bit_ok ? (ONE_W << imm) : ZERO_W;

  // Write arbitration: the memory load path pre-empts any op-based write.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = dst_sel;
    wr_val = ZERO_W;
    if (load_en) begin
      wr_en  = 1'b1;
      wr_val = load_data;
    end else begin
      case (op_s)
        MOV: begin
          wr_en  = 1'b1;
          wr_val = (src_sel == dst_sel) ? ZERO_W : src_data;
        end
        INCR: begin
          wr_en  = 1'b1;
          wr_val = src_data + ONE_W;
        end
        DECR: begin
          wr_en  = 1'b1;
          wr_val = src_data - ONE_W;
        end
        LDV_LO: begin
          wr_en  = 1'b1;
          wr_idx = VREG_IDX;
          wr_val = (vreg_data & ~LO_NIB) | DATA_W'(imm);
        end
        LDV_HI: begin
          wr_en  = HAS_HI;
          wr_idx = VREG_IDX;
          wr_val = (vreg_data & ~HI_NIB) | DATA_W'({imm, 4'h0});
        end
        SETB: begin
          wr_en  = bit_ok;
          wr_val = dst_data | bit_mask;
        end
        FLIPB: begin
          wr_en  = bit_ok;
          wr_val = dst_data ^ bit_mask;
        end
        default: begin
          wr_en = 1'b0;
        end
      endcase
    end
  end

  // Register 0 never takes a write, so it reads zero forever.
  always_comb begin
    for (int i = 0; i < int'(NREGS); i++) begin
      regs_d[i] = (wr_en && (wr_idx == IDX_W'(i)) && (i != int'(REG_ZERO)))
                  ? wr_val : regs_q[i];
    end
  end

  // Register array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= ZERO_W;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  ret_stack #(
    .ADDR_W  (ADDR_W),
    .STACK_D (STACK_D)
  ) u_ret_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (op_s == CALL),
    .pop       (op_s == RET),
    .clr       (op_s == CLRF),
    .push_data (npc),
    .top       (ret_addr),
    .full      (stack_full),
    .empty     (stack_empty),
    .ovf       (ovf),
    .unf       (unf)
  );

endmodule

// File: tb/tb_register_file_p.sv
// Self-checking bench for register_file_p: directed vector table, hand-written
// reset/stack sequences, then randomized ops against a behavioural model.
module tb_register_file_p;
  import rf_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] op, src_sel, dst_sel, imm;
  logic       load_en, stor_en;
  logic [7:0] load_data, src_data, dst_data, stor_data;
  logic [9:0] npc, ret_addr;
  logic       src_zero, stack_full, stack_empty, ovf, unf;

  int checks = 0;
  int errors = 0;

  register_file_p dut (
    .clk(clk), .rst_n(rst_n), .op(op), .src_sel(src_sel), .dst_sel(dst_sel),
    .imm(imm), .load_en(load_en), .load_data(load_data), .stor_en(stor_en),
    .npc(npc), .src_data(src_data), .dst_data(dst_data), .stor_data(stor_data),
    .src_zero(src_zero), .ret_addr(ret_addr), .stack_full(stack_full),
    .stack_empty(stack_empty), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op, src, dst, imm;
    logic       ld;
    logic [7:0] ldd;
    logic [9:0] pc;
    logic [3:0] rd;
    logic [7:0] exp_rd;
    logic [9:0] exp_ret;
    logic       exp_full, exp_empty, exp_ovf, exp_unf;
  } vec_t;

  vec_t vecs[$];

  // behavioural model state
  int m_regs [16];
  int m_stk[$];
  int m_ovf, m_unf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] o, input logic [3:0] s, input logic [3:0] d,
                       input logic [3:0] i, input logic le, input logic [7:0] ld,
                       input logic [9:0] pc);
    op = o; src_sel = s; dst_sel = d; imm = i;
    load_en = le; load_data = ld; npc = pc;
  endtask

  function automatic void add(input logic [3:0] o, input logic [3:0] s, input logic [3:0] d,
                              input logic [3:0] i, input logic le, input logic [7:0] ld,
                              input logic [9:0] pc, input logic [3:0] rd, input logic [7:0] erd,
                              input logic [9:0] eret, input logic ef, input logic ee,
                              input logic eo, input logic eu);
    vec_t v;
    v.op = o; v.src = s; v.dst = d; v.imm = i; v.ld = le; v.ldd = ld; v.pc = pc;
    v.rd = rd; v.exp_rd = erd; v.exp_ret = eret;
    v.exp_full = ef; v.exp_empty = ee; v.exp_ovf = eo; v.exp_unf = eu;
    vecs.push_back(v);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 0;
    m_stk.delete();
    m_ovf = 0;
    m_unf = 0;
  endfunction

  function automatic void model_step(input int o, input int s, input int d, input int i,
                                     input int le, input int ld, input int pc);
    if (le != 0) begin
      m_regs[d] = ld;
    end else begin
      case (o)
        1:  m_regs[d] = (s == d) ? 0 : m_regs[s];
        2:  m_regs[d] = (m_regs[s] + 1) % 256;
        3:  m_regs[d] = (m_regs[s] + 255) % 256;
        4:  m_regs[13] = (m_regs[13] / 16) * 16 + i;
        5:  m_regs[13] = (m_regs[13] % 16) + i * 16;
        6:  if (i < 8) m_regs[d] = m_regs[d] | (1 << i);
        7:  if (i < 8) m_regs[d] = m_regs[d] ^ (1 << i);
        default: ;
      endcase
    end
    m_regs[0] = 0;
    if (o == 8) begin
      if (m_stk.size() == 4) m_ovf = 1; else m_stk.push_back(pc);
    end else if (o == 9) begin
      if (m_stk.size() == 0) m_unf = 1; else void'(m_stk.pop_back());
    end else if (o == 10) begin
      m_ovf = 0;
      m_unf = 0;
    end
  endfunction

  initial begin
    // directed table: op src dst imm ld ldd pc | rd exp_rd exp_ret full empty ovf unf
    add(MOV,    4'd0, 4'd2, 4'd0, 1'b0, 8'h00, 10'h000, 4'd2,  8'h00, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    add(INCR,   4'd2, 4'd2, 4'd0, 1'b0, 8'h00, 10'h000, 4'd2,  8'h01, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    add(INCR,   4'd2, 4'd2, 4'd0, 1'b0, 8'h00, 10'h000, 4'd2,  8'h02, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    add(INCR,   4'd2, 4'd2, 4'd0, 1'b0, 8'h00, 10'h000, 4'd2,  8'h03, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    add(DECR,   4'd0, 4'd3, 4'd0, 1'b0, 8'h00, 10'h000, 4'd3,  8'hFF, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    add(INCR,   4'd4, 4'd4, 4'd0, 1'b1, 8'h5A, 10'h000, 4'd4,  8'h5A, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    add(INCR,   4'd0, 4'd0, 4'd0, 1'b1, 8'h77, 10'h000, 4'd0,  8'h00, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    add(LDV_LO, 4'd0, 4'd0, 4'hC, 1'b0, 8'h00, 10'h000, 4'd13, 8'h0C, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    add(LDV_HI, 4'd0, 4'd0, 4'h3, 1'b0, 8'h00, 10'h000, 4'd13, 8'h3C, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    add(SETB,   4'd0, 4'd5, 4'd7, 1'b0, 8'h00, 10'h000, 4'd5,  8'h80, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    add(FLIPB,  4'd0, 4'd5, 4'd7, 1'b0, 8'h00, 10'h000, 4'd5,  8'h00, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    add(SETB,   4'd0, 4'd5, 4'd0, 1'b0, 8'h00, 10'h000, 4'd5,  8'h01, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    add(SETB,   4'd0, 4'd5, 4'd9, 1'b0, 8'h00, 10'h000, 4'd5,  8'h01, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    add(FLIPB,  4'd0, 4'd5, 4'd9, 1'b0, 8'h00, 10'h000, 4'd5,  8'h01, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    add(MOV,    4'd3, 4'd3, 4'd0, 1'b0, 8'h00, 10'h000, 4'd3,  8'h00, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    add(MOV,    4'd2, 4'd6, 4'd0, 1'b0, 8'h00, 10'h000, 4'd6,  8'h03, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    add(CALL,   4'd0, 4'd0, 4'd0, 1'b0, 8'h00, 10'h101, 4'd6,  8'h03, 10'h101, 1'b0, 1'b0, 1'b0, 1'b0);
    add(CALL,   4'd0, 4'd0, 4'd0, 1'b0, 8'h00, 10'h102, 4'd6,  8'h03, 10'h102, 1'b0, 1'b0, 1'b0, 1'b0);
    add(CALL,   4'd0, 4'd0, 4'd0, 1'b0, 8'h00, 10'h103, 4'd6,  8'h03, 10'h103, 1'b0, 1'b0, 1'b0, 1'b0);
    add(CALL,   4'd0, 4'd0, 4'd0, 1'b0, 8'h00, 10'h104, 4'd6,  8'h03, 10'h104, 1'b1, 1'b0, 1'b0, 1'b0);
    add(CALL,   4'd0, 4'd0, 4'd0, 1'b0, 8'h00, 10'h105, 4'd6,  8'h03, 10'h104, 1'b1, 1'b0, 1'b1, 1'b0);
    add(RET,    4'd0, 4'd0, 4'd0, 1'b0, 8'h00, 10'h000, 4'd6,  8'h03, 10'h103, 1'b0, 1'b0, 1'b1, 1'b0);
    add(RET,    4'd0, 4'd0, 4'd0, 1'b0, 8'h00, 10'h000, 4'd6,  8'h03, 10'h102, 1'b0, 1'b0, 1'b1, 1'b0);
    add(RET,    4'd0, 4'd0, 4'd0, 1'b0, 8'h00, 10'h000, 4'd6,  8'h03, 10'h101, 1'b0, 1'b0, 1'b1, 1'b0);
    add(RET,    4'd0, 4'd0, 4'd0, 1'b0, 8'h00, 10'h000, 4'd6,  8'h03, 10'h000, 1'b0, 1'b1, 1'b1, 1'b0);
    add(RET,    4'd0, 4'd0, 4'd0, 1'b0, 8'h00, 10'h000, 4'd6,  8'h03, 10'h000, 1'b0, 1'b1, 1'b1, 1'b1);
    add(CLRF,   4'd0, 4'd0, 4'd0, 1'b0, 8'h00, 10'h000, 4'd6,  8'h03, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    add(CALL,   4'd0, 4'd7, 4'd0, 1'b1, 8'h11, 10'h2AA, 4'd7,  8'h11, 10'h2AA, 1'b0, 1'b0, 1'b0, 1'b0);
    add(RET,    4'd0, 4'd0, 4'd0, 1'b0, 8'h00, 10'h000, 4'd7,  8'h11, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0);

    // reset state, sampled while reset is held
    rst_n = 1'b0;
    drive(NOP, 4'd0, 4'd0, 4'd0, 1'b0, 8'h00, 10'h000);
    stor_en = 1'b1;
    #2;
    chk("rst_empty", 32'(stack_empty), 32'd1);
    chk("rst_full", 32'(stack_full), 32'd0);
    chk("rst_ret", 32'(ret_addr), 32'd0);
    chk("rst_src_zero", 32'(src_zero), 32'd1);
    chk("rst_stor", 32'(stor_data), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_unf", 32'(unf), 32'd0);
    stor_en = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      src_sel = 4'(i);
      #1 chk($sformatf("rst_reg%0d", i), 32'(src_data), 32'd0);
    end
    @(posedge clk);
    #1;

    // directed table
    foreach (vecs[k]) begin
      drive(vecs[k].op, vecs[k].src, vecs[k].dst, vecs[k].imm, vecs[k].ld, vecs[k].ldd, vecs[k].pc);
      @(posedge clk);
      #1;
      drive(NOP, vecs[k].rd, 4'd0, 4'd0, 1'b0, 8'h00, 10'h000);
      #1;
      chk($sformatf("v%0d_rd", k), 32'(src_data), 32'(vecs[k].exp_rd));
      chk($sformatf("v%0d_ret", k), 32'(ret_addr), 32'(vecs[k].exp_ret));
      chk($sformatf("v%0d_full", k), 32'(stack_full), 32'(vecs[k].exp_full));
      chk($sformatf("v%0d_empty", k), 32'(stack_empty), 32'(vecs[k].exp_empty));
      chk($sformatf("v%0d_ovf", k), 32'(ovf), 32'(vecs[k].exp_ovf));
      chk($sformatf("v%0d_unf", k), 32'(unf), 32'(vecs[k].exp_unf));
    end

    // RET: ret_addr shows the pre-pop entry during the RET cycle
    drive(CALL, 4'd0, 4'd0, 4'd0, 1'b0, 8'h00, 10'h3C1);
    @(posedge clk);
    #1 drive(RET, 4'd0, 4'd0, 4'd0, 1'b0, 8'h00, 10'h000);
    #1 chk("ret_same_cycle", 32'(ret_addr), 32'h3C1);
    @(posedge clk);
    #1 drive(NOP, 4'd0, 4'd0, 4'd0, 1'b0, 8'h00, 10'h000);
    chk("ret_after_empty", 32'(stack_empty), 32'd1);
    chk("ret_after_addr", 32'(ret_addr), 32'd0);

    // asynchronous reset mid-INCR with a non-empty stack
    drive(CALL, 4'd0, 4'd0, 4'd0, 1'b0, 8'h00, 10'h123);
    @(posedge clk);
    #1 drive(INCR, 4'd2, 4'd2, 4'd0, 1'b0, 8'h00, 10'h000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_r2", 32'(src_data), 32'd0);
    chk("arst_empty", 32'(stack_empty), 32'd1);
    chk("arst_ret", 32'(ret_addr), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(NOP, 4'd2, 4'd2, 4'd0, 1'b0, 8'h00, 10'h000);
    #1 chk("arst_noupd_r2", 32'(src_data), 32'd0);
    // asynchronous reset mid-CALL
    drive(CALL, 4'd2, 4'd2, 4'd0, 1'b0, 8'h00, 10'h077);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("arst_call_empty", 32'(stack_empty), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(NOP, 4'd2, 4'd2, 4'd0, 1'b0, 8'h00, 10'h000);
    #1;
    chk("arst_call_noupd", 32'(stack_empty), 32'd1);
    chk("arst_call_ret", 32'(ret_addr), 32'd0);
    @(posedge clk);
    #1 chk("post_rst_r2", 32'(src_data), 32'd0);

    // randomized ops against the model (state is all-zero after the reset above)
    model_reset();
    for (int n = 0; n < 400; n++) begin
      int o, s, d, i, le, ld, pc, exp_ret;
      o  = int'($urandom_range(0, 15));
      s  = int'($urandom_range(0, 15));
      d  = int'($urandom_range(0, 15));
      i  = int'($urandom_range(0, 15));
      le = ($urandom_range(0, 3) == 0) ? 1 : 0;
      ld = int'($urandom_range(0, 255));
      pc = int'($urandom_range(0, 1023));
      drive(4'(o), 4'(s), 4'(d), 4'(i), 1'(le), 8'(ld), 10'(pc));
      stor_en = 1'($urandom_range(0, 1));
      #1;
      exp_ret = (m_stk.size() > 0) ? m_stk[$] : 0;
      chk("rnd_src", 32'(src_data), 32'(m_regs[s]));
      chk("rnd_dst", 32'(dst_data), 32'(m_regs[d]));
      chk("rnd_stor", 32'(stor_data), stor_en ? 32'(m_regs[s]) : 32'd0);
      chk("rnd_zero", 32'(src_zero), (m_regs[s] == 0) ? 32'd1 : 32'd0);
      chk("rnd_ret", 32'(ret_addr), 32'(exp_ret));
      chk("rnd_full", 32'(stack_full), (m_stk.size() == 4) ? 32'd1 : 32'd0);
      chk("rnd_empty", 32'(stack_empty), (m_stk.size() == 0) ? 32'd1 : 32'd0);
      chk("rnd_ovf", 32'(ovf), 32'(m_ovf));
      chk("rnd_unf", 32'(unf), 32'(m_unf));
      model_step(o, s, d, i, le, ld, pc);
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
